// File: rtl/decode_stage.sv
// Decode stage: field decode, 8x16 register file, load-use hazard detection, ID/EX register.
// Optional macro DECODE_BYPASS_EN: forwards a same-cycle write-back onto the read ports.
module decode_stage #(
    parameter logic [4:0] LOAD_OP  = 5'b10001,
    parameter logic [4:0] STORE_OP = 5'b10000,
    parameter int         NREGS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] NextPC,
    input  logic [15:0] Instruct,
    input  logic        Flush,
    input  logic        WbWrite,
    input  logic [2:0]  WbReg,
    input  logic [15:0] WbData,
    output logic        Stall,
    output logic        ExValid,
    output logic [15:0] ExPC,
    output logic [4:0]  ExOpcode,
    output logic [2:0]  ExRd,
    output logic [2:0]  ExRs,
    output logic [2:0]  ExRt,
    output logic [15:0] ExRsData,
    output logic [15:0] ExRtData,
    output logic [15:0] ExImm,
    output logic        ExMemRead,
    output logic        ExMemWrite,
    output logic        ExRegWrite
);
    logic [15:0] r_regs [NREGS];

    logic [4:0]  w_opcode;
    logic [2:0]  w_rd, w_rs, w_rt;
    logic [15:0] w_imm;
    logic        w_is_nop, w_is_branch, w_uses_rt;
    logic        w_mem_read, w_mem_write, w_reg_write;
    logic [15:0] w_rs_data, w_rt_data;
    logic        w_hazard;

    logic        r_ex_valid;
    logic [15:0] r_ex_pc;
    logic [4:0]  r_ex_opcode;
    logic [2:0]  r_ex_rd, r_ex_rs, r_ex_rt;
    logic [15:0] r_ex_rs_data, r_ex_rt_data, r_ex_imm;
    logic        r_ex_mem_read, r_ex_mem_write, r_ex_reg_write;

    assign w_opcode = Instruct[15:11];
    assign w_rd     = Instruct[10:8];
    assign w_rs     = Instruct[7:5];
    assign w_rt     = Instruct[4:2];
    assign w_imm    = {{8{Instruct[7]}}, Instruct[7:0]};

    assign w_is_nop    = (w_opcode == 5'b00000);
    assign w_is_branch = (w_opcode[4:3] == 2'b11);
    assign w_uses_rt   = ~w_opcode[4] & ~w_is_nop;
    assign w_mem_read  = (w_opcode == LOAD_OP);
    assign w_mem_write = (w_opcode == STORE_OP);
    assign w_reg_write = ~w_is_nop & ~w_mem_write & ~w_is_branch;

    // Register file write port; r0 is never written so it stays architecturally zero.
    always_ff @(posedge clk) begin
        if (WbWrite && (WbReg != 3'd0)) begin
            r_regs[WbReg] <= WbData;
        end
    end

    // Asynchronous read ports, with optional write-then-read forwarding.
    always_comb begin
        w_rs_data = 16'd0;
        w_rt_data = 16'd0;
        if (w_rs != 3'd0) begin
            w_rs_data = r_regs[w_rs];
        end else begin
            w_rs_data = 16'd0;
        end
        if (w_rt != 3'd0) begin
            w_rt_data = r_regs[w_rt];
        end else begin
            w_rt_data = 16'd0;
        end
`ifdef DECODE_BYPASS_EN
        if (WbWrite && (WbReg != 3'd0) && (WbReg == w_rs)) begin
            w_rs_data = WbData;
        end else begin
            w_rs_data = w_rs_data;
        end
        if (WbWrite && (WbReg != 3'd0) && (WbReg == w_rt)) begin
            w_rt_data = WbData;
        end else begin
            w_rt_data = w_rt_data;
        end
`endif
    end

    // The bubble clears ExMemRead, so a hazard can only hold for one cycle.
    assign w_hazard = r_ex_valid & r_ex_mem_read & (r_ex_rd != 3'd0) &
                      ((r_ex_rd == w_rs) | (w_uses_rt & (r_ex_rd == w_rt)));
    assign Stall    = w_hazard & ~Flush;

    // ID/EX pipeline register: reset, then flush/stall bubble, then normal load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_pc        <= 16'd0;
            r_ex_opcode    <= 5'd0;
            r_ex_rd        <= 3'd0;
            r_ex_rs        <= 3'd0;
            r_ex_rt        <= 3'd0;
            r_ex_rs_data   <= 16'd0;
            r_ex_rt_data   <= 16'd0;
            r_ex_imm       <= 16'd0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_reg_write <= 1'b0;
        end else if (Flush || w_hazard) begin
            r_ex_valid     <= 1'b0;
            r_ex_pc        <= 16'd0;
            r_ex_opcode    <= 5'd0;
            r_ex_rd        <= 3'd0;
            r_ex_rs        <= 3'd0;
            r_ex_rt        <= 3'd0;
            r_ex_rs_data   <= 16'd0;
            r_ex_rt_data   <= 16'd0;
            r_ex_imm       <= 16'd0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_reg_write <= 1'b0;
        end else begin
            r_ex_valid     <= 1'b1;
            r_ex_pc        <= NextPC;
            r_ex_opcode    <= w_opcode;
            r_ex_rd        <= w_rd;
            r_ex_rs        <= w_rs;
            r_ex_rt        <= w_rt;
            r_ex_rs_data   <= w_rs_data;
            r_ex_rt_data   <= w_rt_data;
            r_ex_imm       <= w_imm;
            r_ex_mem_read  <= w_mem_read;
            r_ex_mem_write <= w_mem_write;
            r_ex_reg_write <= w_reg_write;
        end
    end

    assign ExValid    = r_ex_valid;
    assign ExPC       = r_ex_pc;
    assign ExOpcode   = r_ex_opcode;
    assign ExRd       = r_ex_rd;
    assign ExRs       = r_ex_rs;
    assign ExRt       = r_ex_rt;
    assign ExRsData   = r_ex_rs_data;
    assign ExRtData   = r_ex_rt_data;
    assign ExImm      = r_ex_imm;
    assign ExMemRead  = r_ex_mem_read;
    assign ExMemWrite = r_ex_mem_write;
    assign ExRegWrite = r_ex_reg_write;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expectations, a negedge monitor compares.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] NextPC, Instruct, WbData;
    logic        Flush, WbWrite;
    logic [2:0]  WbReg;
    logic        Stall, ExValid, ExMemRead, ExMemWrite, ExRegWrite;
    logic [15:0] ExPC, ExRsData, ExRtData, ExImm;
    logic [4:0]  ExOpcode;
    logic [2:0]  ExRd, ExRs, ExRt;

    decode_stage dut (
        .clk(clk), .rst(rst), .NextPC(NextPC), .Instruct(Instruct), .Flush(Flush),
        .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData), .Stall(Stall),
        .ExValid(ExValid), .ExPC(ExPC), .ExOpcode(ExOpcode), .ExRd(ExRd), .ExRs(ExRs),
        .ExRt(ExRt), .ExRsData(ExRsData), .ExRtData(ExRtData), .ExImm(ExImm),
        .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExRegWrite(ExRegWrite)
    );

    always #5 clk = ~clk;

`ifdef DECODE_BYPASS_EN
    localparam logic [15:0] BYP4 = 16'h4444;
    localparam logic [15:0] BYP6 = 16'h6666;
`else
    localparam logic [15:0] BYP4 = 16'h0000;
    localparam logic [15:0] BYP6 = 16'h0000;
`endif

    typedef struct packed {
        logic [31:0]  due;
        logic [31:0]  idx;
        logic [127:0] exp;
    } sb_t;

    sb_t         stall_q[$];
    sb_t         ex_q[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          vidx = 0;
    logic [15:0] pc = 16'h0100;

    wire [127:0] w_act = {46'd0, ExValid, ExPC, ExOpcode, ExRd, ExRs, ExRt,
                          ExRsData, ExRtData, ExImm, ExMemRead, ExMemWrite, ExRegWrite};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        sb_t e;
        while (stall_q.size() > 0 && stall_q[0].due == cyc) begin
            e = stall_q.pop_front();
            check($sformatf("stall_v%0d", e.idx), {127'd0, Stall}, e.exp);
        end
        while (ex_q.size() > 0 && ex_q[0].due == cyc) begin
            e = ex_q.pop_front();
            check($sformatf("idex_v%0d", e.idx), w_act, e.exp);
        end
    end

    // Apply one decode cycle and queue its hand-computed Stall and ID/EX expectations.
    task automatic drive(input logic [15:0] ins, input logic fl, input logic wbw,
                         input logic [2:0] wr, input logic [15:0] wd, input logic st,
                         input logic vl, input logic [15:0] rsd, input logic [15:0] rtd,
                         input logic [15:0] imm, input logic mr, input logic mw, input logic rw);
        sb_t s;
        sb_t x;
        Instruct = ins; Flush = fl; WbWrite = wbw; WbReg = wr; WbData = wd; NextPC = pc;
        s.due = cyc; s.idx = vidx; s.exp = {127'd0, st};
        x.due = cyc + 1; x.idx = vidx;
        if (vl) x.exp = {46'd0, 1'b1, pc, ins[15:11], ins[10:8], ins[7:5], ins[4:2],
                         rsd, rtd, imm, mr, mw, rw};
        else    x.exp = 128'd0;
        stall_q.push_back(s);
        ex_q.push_back(x);
        vidx++;
        pc = pc + 16'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Instruct = 16'h0000; Flush = 1'b0; WbWrite = 1'b0;
        WbReg = 3'd0; WbData = 16'h0000; NextPC = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_idex", w_act, 128'd0);
        check("reset_stall", {127'd0, Stall}, 128'd0);
        rst = 1'b0;
        // clear r1..r7 through the write port while decoding NOPs
        for (int i = 1; i < 8; i++)
            drive(16'h0000, 1'b0, 1'b1, 3'(i), 16'h0000, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        //    instr     fl    wbw   wreg  wdata     st    vl    rsd       rtd       imm       mr    mw    rw
        drive(16'h0000, 1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(16'h0960, 1'b0, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 16'hBEEF, 16'h0000, 16'h0060, 1'b0, 1'b0, 1'b1);
        drive(16'h0000, 1'b0, 1'b1, 3'd0, 16'h1234, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(16'h0900, 1'b0, 1'b1, 3'd5, 16'h5555, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        // load r2, R-type consumer via rt: one stall, one bubble, then issue
        drive(16'h8AA0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5555, 16'h0000, 16'hFFA0, 1'b1, 1'b0, 1'b1);
        drive(16'h0B28, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(16'h0B28, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h2222, 16'h0028, 1'b0, 1'b0, 1'b1);
        // load r2, I-type with rt field 2 but rs 5: no stall
        drive(16'h8AA0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5555, 16'h0000, 16'hFFA0, 1'b1, 1'b0, 1'b1);
        drive(16'h91A8, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5555, 16'h2222, 16'hFFA8, 1'b0, 1'b0, 1'b1);
        // flush wins over a pending hazard
        drive(16'h8AA0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5555, 16'h0000, 16'hFFA0, 1'b1, 1'b0, 1'b1);
        drive(16'h0B28, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(16'h0B28, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h2222, 16'h0028, 1'b0, 1'b0, 1'b1);
        // back-to-back loads to r2: each dependent consumer stalls once
        drive(16'h8AA0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5555, 16'h0000, 16'hFFA0, 1'b1, 1'b0, 1'b1);
        drive(16'h8A40, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(16'h8A40, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h2222, 16'h0000, 16'h0040, 1'b1, 1'b0, 1'b1);
        drive(16'h0B28, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(16'h0B28, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h2222, 16'h0028, 1'b0, 1'b0, 1'b1);
        // stores (positive and negative imm) and a branch-class opcode
        drive(16'h8150, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h2222, 16'h0000, 16'h0050, 1'b0, 1'b1, 1'b0);
        drive(16'h8180, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFF80, 1'b0, 1'b1, 1'b0);
        drive(16'hC120, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0020, 1'b0, 1'b0, 1'b0);
        // same-cycle write-back to the register being read
        drive(16'h0980, 1'b0, 1'b1, 3'd4, 16'h4444, 1'b0, 1'b1, BYP4,     16'h0000, 16'hFF80, 1'b0, 1'b0, 1'b1);
        drive(16'h0980, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h4444, 16'h0000, 16'hFF80, 1'b0, 1'b0, 1'b1);
        drive(16'h0918, 1'b0, 1'b1, 3'd6, 16'h6666, 1'b0, 1'b1, 16'h0000, BYP6,     16'h0018, 1'b0, 1'b0, 1'b1);
        drive(16'h8AA0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5555, 16'h0000, 16'hFFA0, 1'b1, 1'b0, 1'b1);
        // ID/EX holds the load; present a consumer, then reset mid-cycle
        Instruct = 16'h0B28;
        #1;
        check("hazard_before_rst", {127'd0, Stall}, 128'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_idex", w_act, 128'd0);
        check("rst_async_stall", {127'd0, Stall}, 128'd0);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 8; k++)
            if (stall_q.size() != 0 || ex_q.size() != 0) @(posedge clk);
        check("scoreboard_drained", 128'(stall_q.size() + ex_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
